// File: rtl/cellrv32_package.sv
// rtl/cellrv32_package.sv - shared types and defaults for the VRF write arbiter
package cellrv32_package;

    typedef enum logic [0:0] {
        PRIO_EX  = 1'b0,
        PRIO_MEM = 1'b1
    } vrf_arb_state_t;

    localparam int VRF_ARB_MAX_WAIT_DEF = 3;

endpackage

// File: rtl/vrf_wr_arb_fsm.sv
// rtl/vrf_wr_arb_fsm.sv - conflict priority FSM and bounded wait counter for the VRF write arbiter
// Optional forced-switch pulse output under CELLRV32_VRF_ARB_STATS_EN.
module vrf_wr_arb_fsm
    import cellrv32_package::*;
#(
    parameter int MAX_WAIT = VRF_ARB_MAX_WAIT_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic conflict_i,
    input  logic ex_grant_i,
    input  logic mem_grant_i,
    output logic ex_wins_o
`ifdef CELLRV32_VRF_ARB_STATS_EN
    ,
    output logic forced_o
`endif
);

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    vrf_arb_state_t state_q;
    logic [CW-1:0]  wait_q;
    logic           loser_xfer;
    logic           wait_done;

    // The counter always tracks the requester without priority.
    assign loser_xfer = (state_q == PRIO_EX) ? mem_grant_i : ex_grant_i;
    assign wait_done  = (wait_q == CW'(MAX_WAIT - 1));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= PRIO_EX;
            wait_q  <= '0;
        end else if (conflict_i) begin
            if (wait_done) begin
                state_q <= (state_q == PRIO_EX) ? PRIO_MEM : PRIO_EX;
                wait_q  <= '0;
            end else begin
                wait_q <= wait_q + CW'(1);
            end
        end else if (loser_xfer) begin
            wait_q <= '0;
        end
    end

    assign ex_wins_o = (state_q == PRIO_EX);

`ifdef CELLRV32_VRF_ARB_STATS_EN
    assign forced_o = conflict_i & wait_done;
`endif

endmodule

// File: rtl/vrf_wr_arbiter.sv
// rtl/vrf_wr_arbiter.sv - registered arbiter sharing the VRF register and element write ports
// Optional conflict/starvation counters under CELLRV32_VRF_ARB_STATS_EN.
module vrf_wr_arbiter
    import cellrv32_package::*;
#(
    parameter int VREGS      = 32,
    parameter int ELEMENTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = VRF_ARB_MAX_WAIT_DEF,
    localparam int AW        = $clog2(VREGS)
) (
    input  logic                                 clk_i,
    input  logic                                 rstn_i,
    input  logic                                 ex_valid_i,
    output logic                                 ex_ready_o,
    input  logic [AW-1:0]                        ex_addr_i,
    input  logic [ELEMENTS-1:0]                  ex_mask_i,
    input  logic [ELEMENTS*DATA_WIDTH-1:0]       ex_data_i,
    input  logic                                 mem_valid_i,
    output logic                                 mem_ready_o,
    input  logic [AW-1:0]                        mem_addr_i,
    input  logic [ELEMENTS-1:0]                  mem_mask_i,
    input  logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  mem_data_i,
    output logic [ELEMENTS-1:0]                  v_wr_en_o,
    output logic [AW-1:0]                        v_wr_addr_o,
    output logic [ELEMENTS*DATA_WIDTH-1:0]       v_wr_data_o,
    output logic [ELEMENTS-1:0]                  el_wr_en_o,
    output logic [AW-1:0]                        el_wr_addr_o,
    output logic [ELEMENTS-1:0][DATA_WIDTH-1:0]  el_wr_data_o,
    output logic [VREGS-1:0]                     pend_o
`ifdef CELLRV32_VRF_ARB_STATS_EN
    ,
    output logic [31:0]                          conflict_cnt_o,
    output logic [31:0]                          starve_cnt_o
`endif
);

    logic conflict;
    logic ex_wins;
    logic ex_xfer;
    logic mem_xfer;

    // Only overlapping element enables collide inside the VRF; the register address is irrelevant.
    assign conflict    = ex_valid_i & mem_valid_i & (|(ex_mask_i & mem_mask_i));
    assign ex_ready_o  = rstn_i & ex_valid_i  & (~conflict | ex_wins);
    assign mem_ready_o = rstn_i & mem_valid_i & (~conflict | ~ex_wins);
    assign ex_xfer     = ex_ready_o;
    assign mem_xfer    = mem_ready_o;

`ifdef CELLRV32_VRF_ARB_STATS_EN
    logic forced;
`endif

    vrf_wr_arb_fsm #(
        .MAX_WAIT (MAX_WAIT)
    ) u_fsm (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .conflict_i  (conflict),
        .ex_grant_i  (ex_xfer),
        .mem_grant_i (mem_xfer),
        .ex_wins_o   (ex_wins)
`ifdef CELLRV32_VRF_ARB_STATS_EN
        ,
        .forced_o    (forced)
`endif
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v_wr_en_o    <= '0;
            v_wr_addr_o  <= '0;
            v_wr_data_o  <= '0;
            el_wr_en_o   <= '0;
            el_wr_addr_o <= '0;
            el_wr_data_o <= '0;
        end else begin
            v_wr_en_o    <= ex_xfer  ? ex_mask_i  : '0;
            v_wr_addr_o  <= ex_xfer  ? ex_addr_i  : '0;
            v_wr_data_o  <= ex_xfer  ? ex_data_i  : '0;
            el_wr_en_o   <= mem_xfer ? mem_mask_i : '0;
            el_wr_addr_o <= mem_xfer ? mem_addr_i : '0;
            el_wr_data_o <= mem_xfer ? mem_data_i : '0;
        end
    end

    always_comb begin
        pend_o = '0;
        if (|v_wr_en_o) begin
            pend_o[v_wr_addr_o] = 1'b1;
        end
        if (|el_wr_en_o) begin
            pend_o[el_wr_addr_o] = 1'b1;
        end
    end

`ifdef CELLRV32_VRF_ARB_STATS_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            conflict_cnt_o <= '0;
            starve_cnt_o   <= '0;
        end else begin
            if (conflict && (conflict_cnt_o != '1)) begin
                conflict_cnt_o <= conflict_cnt_o + 32'd1;
            end
            if (forced && (starve_cnt_o != '1)) begin
                starve_cnt_o <= starve_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_vrf_wr_arbiter.sv
// tb/tb_vrf_wr_arbiter.sv - scoreboard bench for vrf_wr_arbiter with directed and random traffic
module tb_vrf_wr_arbiter;

    localparam int MAX_WAIT = 3;

    logic              clk_i = 1'b0;
    logic              rstn_i;
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [4:0]        ex_addr_i;
    logic [3:0]        ex_mask_i;
    logic [127:0]      ex_data_i;
    logic              mem_valid_i;
    logic              mem_ready_o;
    logic [4:0]        mem_addr_i;
    logic [3:0]        mem_mask_i;
    logic [3:0][31:0]  mem_data_i;
    logic [3:0]        v_wr_en_o;
    logic [4:0]        v_wr_addr_o;
    logic [127:0]      v_wr_data_o;
    logic [3:0]        el_wr_en_o;
    logic [4:0]        el_wr_addr_o;
    logic [3:0][31:0]  el_wr_data_o;
    logic [31:0]       pend_o;
`ifdef CELLRV32_VRF_ARB_STATS_EN
    logic [31:0]       conflict_cnt;
    logic [31:0]       starve_cnt;
`endif

    vrf_wr_arbiter dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .ex_valid_i   (ex_valid_i),
        .ex_ready_o   (ex_ready_o),
        .ex_addr_i    (ex_addr_i),
        .ex_mask_i    (ex_mask_i),
        .ex_data_i    (ex_data_i),
        .mem_valid_i  (mem_valid_i),
        .mem_ready_o  (mem_ready_o),
        .mem_addr_i   (mem_addr_i),
        .mem_mask_i   (mem_mask_i),
        .mem_data_i   (mem_data_i),
        .v_wr_en_o    (v_wr_en_o),
        .v_wr_addr_o  (v_wr_addr_o),
        .v_wr_data_o  (v_wr_data_o),
        .el_wr_en_o   (el_wr_en_o),
        .el_wr_addr_o (el_wr_addr_o),
        .el_wr_data_o (el_wr_data_o),
        .pend_o       (pend_o)
`ifdef CELLRV32_VRF_ARB_STATS_EN
        ,
        .conflict_cnt_o (conflict_cnt),
        .starve_cnt_o   (starve_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]   v_en;
        logic [4:0]   v_addr;
        logic [127:0] v_data;
        logic [3:0]   el_en;
        logic [4:0]   el_addr;
        logic [127:0] el_data;
        logic [31:0]  pend;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    // Reference model: who wins conflicts (0 = EX, 1 = MEM) and how many conflicts the other side has lost.
    int   favored = 0;
    int   losses  = 0;
    logic last_er, last_mr;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    task automatic model_reset();
        favored = 0;
        losses  = 0;
        exp_q.delete();
    endtask

    task automatic drive(input logic ev, input logic [4:0] ea, input logic [3:0] em, input logic [127:0] ed,
                         input logic mv, input logic [4:0] ma, input logic [3:0] mm, input logic [127:0] md,
                         output logic ex_acc, output logic mem_acc);
        exp_t e;
        logic conf;
        @(negedge clk_i);
        ex_valid_i  = ev;  ex_addr_i  = ea;  ex_mask_i  = em;  ex_data_i  = ed;
        mem_valid_i = mv;  mem_addr_i = ma;  mem_mask_i = mm;  mem_data_i = md;
        #1;
        conf    = ev && mv && ((em & mm) != 4'd0);
        ex_acc  = ev && (!conf || favored == 0);
        mem_acc = mv && (!conf || favored == 1);
        last_er = ex_ready_o;
        last_mr = mem_ready_o;
        check("ex_ready", {127'd0, last_er}, {127'd0, ex_acc});
        check("mem_ready", {127'd0, last_mr}, {127'd0, mem_acc});
        e.v_en    = ex_acc  ? em : 4'd0;
        e.v_addr  = ex_acc  ? ea : 5'd0;
        e.v_data  = ex_acc  ? ed : 128'd0;
        e.el_en   = mem_acc ? mm : 4'd0;
        e.el_addr = mem_acc ? ma : 5'd0;
        e.el_data = mem_acc ? md : 128'd0;
        e.pend    = 32'd0;
        if (e.v_en != 4'd0)  e.pend = e.pend | (32'd1 << ea);
        if (e.el_en != 4'd0) e.pend = e.pend | (32'd1 << ma);
        exp_q.push_back(e);
        if (conf) begin
            losses++;
            if (losses == MAX_WAIT) begin
                favored = 1 - favored;
                losses  = 0;
            end
        end else if ((favored == 0 && mem_acc) || (favored == 1 && ex_acc)) begin
            losses = 0;
        end
    endtask

    task automatic idle();
        logic a, b;
        drive(1'b0, 5'd0, 4'd0, 128'd0, 1'b0, 5'd0, 4'd0, 128'd0, a, b);
    endtask

    // Monitor: compares the output stage against the oldest expectation after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("v_wr_en", {124'd0, v_wr_en_o}, {124'd0, e.v_en});
                check("v_wr_addr", {123'd0, v_wr_addr_o}, {123'd0, e.v_addr});
                check("v_wr_data", v_wr_data_o, e.v_data);
                check("el_wr_en", {124'd0, el_wr_en_o}, {124'd0, e.el_en});
                check("el_wr_addr", {123'd0, el_wr_addr_o}, {123'd0, e.el_addr});
                check("el_wr_data", el_wr_data_o, e.el_data);
                check("pend", {96'd0, pend_o}, {96'd0, e.pend});
            end else begin
                check("idle_enables", {92'd0, pend_o, v_wr_en_o, el_wr_en_o}, 128'd0);
            end
        end
    end

    initial begin
        logic a, b;
        logic        re_v, rm_v, acc_e, acc_m;
        logic [4:0]  re_a, rm_a;
        logic [3:0]  re_m, rm_m;
        logic [127:0] re_d, rm_d;

        rstn_i = 1'b0;
        ex_valid_i = 1'b1; ex_addr_i = 5'd1; ex_mask_i = 4'hF; ex_data_i = 128'd0;
        mem_valid_i = 1'b0; mem_addr_i = 5'd0; mem_mask_i = 4'd0; mem_data_i = '0;
        repeat (3) @(posedge clk_i);
        #2;
        check("reset_ex_ready", {127'd0, ex_ready_o}, 128'd0);
        check("reset_outputs", {92'd0, pend_o, v_wr_en_o, el_wr_en_o}, 128'd0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        ex_valid_i = 1'b0;

        // Same register, disjoint masks: both ports written together.
        drive(1'b1, 5'd5, 4'b0011, {4{32'h1111_2222}}, 1'b1, 5'd5, 4'b1100, {4{32'h3333_4444}}, a, b);
        check("disjoint_ex_ready", {127'd0, last_er}, 128'd1);
        check("disjoint_mem_ready", {127'd0, last_mr}, 128'd1);
        idle();
        check("disjoint_v_en", {124'd0, v_wr_en_o}, 128'h3);
        check("disjoint_el_en", {124'd0, el_wr_en_o}, 128'hC);
        check("disjoint_pend", {96'd0, pend_o}, 128'h20);

        // Starvation: EX wins three conflicts, MEM is forced through on the fourth.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(k), 4'b0001, {4{$urandom}}, 1'b1, 5'd7, 4'b0001, {4{32'hA5A5_0007}}, a, b);
            check("starve_ex_ready", {127'd0, last_er}, {127'd0, (k < 3)});
            check("starve_mem_ready", {127'd0, last_mr}, {127'd0, (k == 3)});
        end
`ifdef CELLRV32_VRF_ARB_STATS_EN
        @(posedge clk_i);
        #2;
        check("conflict_cnt", {96'd0, conflict_cnt}, 128'd4);
        check("starve_cnt", {96'd0, starve_cnt}, 128'd1);
`endif
        // MEM now holds priority; build up EX losses, then reset right after a handshake.
        drive(1'b1, 5'd3, 4'b0001, 128'd9, 1'b1, 5'd8, 4'b0001, 128'd8, a, b);
        check("prio_mem_win", {126'd0, last_er, last_mr}, 128'b01);
        drive(1'b1, 5'd3, 4'b0001, 128'd9, 1'b1, 5'd9, 4'b0011, 128'd7, a, b);
        check("prio_mem_win2", {126'd0, last_er, last_mr}, 128'b01);
        @(posedge clk_i);
        #3;
        rstn_i = 1'b0;
        #1;
        check("midreset_enables", {92'd0, pend_o, v_wr_en_o, el_wr_en_o}, 128'd0);
        check("midreset_data", {v_wr_data_o[63:0], el_wr_data_o[63:0]}, 128'd0);
        check("midreset_ready", {126'd0, ex_ready_o, mem_ready_o}, 128'd0);
        model_reset();
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        ex_valid_i = 1'b0;
        mem_valid_i = 1'b0;

        // After reset: EX priority and an empty wait counter again.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'(10 + k), 4'b0010, {4{$urandom}}, 1'b1, 5'd20, 4'b0110, {4{$urandom}}, a, b);
            check("postreset_ex_ready", {127'd0, last_er}, {127'd0, (k < 3)});
        end
        drive(1'b1, 5'd13, 4'b0010, 128'd1, 1'b0, 5'd0, 4'd0, 128'd0, a, b);

        // Full-register write to the top register: one-cycle pend pulse.
        drive(1'b1, 5'd31, 4'b1111, {4{32'hDEAD_BEEF}}, 1'b0, 5'd0, 4'd0, 128'd0, a, b);
        idle();
        check("full_v_en", {124'd0, v_wr_en_o}, 128'hF);
        check("full_v_data", v_wr_data_o, {4{32'hDEAD_BEEF}});
        check("full_pend", {96'd0, pend_o}, 128'h8000_0000);
        idle();
        check("full_pend_drop", {96'd0, pend_o}, 128'd0);

        // Zero mask never conflicts and writes nothing.
        drive(1'b1, 5'd2, 4'b0000, 128'd5, 1'b1, 5'd2, 4'b1111, {4{32'h0BAD_F00D}}, a, b);
        check("zero_mask_ready", {126'd0, last_er, last_mr}, 128'b11);
        idle();
        check("zero_mask_en", {120'd0, v_wr_en_o, el_wr_en_o}, 128'h0F);

        // Random traffic; requests stay stable until accepted.
        re_v = 1'b0; rm_v = 1'b0; acc_e = 1'b0; acc_m = 1'b0;
        re_a = '0; rm_a = '0; re_m = '0; rm_m = '0; re_d = '0; rm_d = '0;
        for (int i = 0; i < 400; i++) begin
            if (!re_v || acc_e) begin
                re_v = ($urandom_range(0, 3) != 0);
                re_a = 5'($urandom_range(0, 31));
                re_m = 4'($urandom_range(0, 15));
                re_d = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!rm_v || acc_m) begin
                rm_v = ($urandom_range(0, 3) != 0);
                rm_a = 5'($urandom_range(0, 31));
                rm_m = 4'($urandom_range(0, 15));
                rm_d = {$urandom, $urandom, $urandom, $urandom};
            end
            drive(re_v, re_a, re_m, re_d, rm_v, rm_a, rm_m, rm_d, acc_e, acc_m);
        end
        idle();
        idle();
        @(posedge clk_i);
        #2;
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vrf_wr_arbiter.md
Name: vrf_wr_arbiter

Overview:
- Shares the two write ports of the vector register file (VRF) between two requesters.
- Requester EX is the vector execution unit, writing whole registers with an element mask; it drives the VRF register write port.
- Requester MEM is the vector load unit, writing individual elements; it drives the VRF element write port.
- Registered single-stage arbiter. Guarantees no accepted element write is silently dropped by the VRF's per-element port priority. Exports a pending-write vector for RAW hazard stalls.

Parameters:
- VREGS, 32, number of vector registers
- ELEMENTS, 4, elements per vector register
- DATA_WIDTH, 32, bits per element
- MAX_WAIT, 3, consecutive conflict losses a requester may suffer before it is forced to win

Ports:
- clk_i  in  1  clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- ex_valid_i  in  1  EX write request
- ex_ready_o  out  1  EX request accepted this cycle
- ex_addr_i  in  $clog2(VREGS)  EX destination register
- ex_mask_i  in  ELEMENTS  EX element enables
- ex_data_i  in  ELEMENTS*DATA_WIDTH  EX flat register data; element k at [k*DATA_WIDTH +: DATA_WIDTH]
- mem_valid_i  in  1  MEM write request
- mem_ready_o  out  1  MEM request accepted this cycle
- mem_addr_i  in  $clog2(VREGS)  MEM destination register
- mem_mask_i  in  ELEMENTS  MEM element enables
- mem_data_i  in  ELEMENTS x DATA_WIDTH  MEM packed per-element data
- v_wr_en_o  out  ELEMENTS  to VRF register write port
- v_wr_addr_o  out  $clog2(VREGS)  to VRF register write port
- v_wr_data_o  out  ELEMENTS*DATA_WIDTH  to VRF register write port
- el_wr_en_o  out  ELEMENTS  to VRF element write port
- el_wr_addr_o  out  $clog2(VREGS)  to VRF element write port
- el_wr_data_o  out  ELEMENTS x DATA_WIDTH  to VRF element write port
- pend_o  out  VREGS  bit r set: a write to register r is in the output stage this cycle

Behaviour:
- Handshake: transfer occurs when valid and ready are both high. Ready is combinational from the current valid/mask/state and does not depend on the other requester's ready. Requesters hold their request stable until accepted.
- Conflict: conflict = ex_valid_i & mem_valid_i & |(ex_mask_i & mem_mask_i). Address equality is irrelevant.
- No conflict: every valid requester gets ready=1. Both may transfer in the same cycle.
- Conflict: exactly one requester is granted. The winner is set by the FSM:
  - PRIO_EX: EX wins.
  - PRIO_MEM: MEM wins.
- Wait counter: one MAX_WAIT-bounded counter for the current loser. Increment on each conflict lost.
- When the counter reaches MAX_WAIT: switch FSM to the loser's priority and clear the counter.
- A non-conflicting cycle in which the waiting requester transfers clears the counter. The FSM is unchanged.
- Reset state: PRIO_EX, counter 0.
- Output stage: on an accepted transfer, capture addr/mask/data into the port registers.
  - EX goes to the v_wr_* outputs; MEM goes to the el_wr_* outputs.
  - Enables equal the mask. Enables are 0 in any cycle with no transfer.
  - Latency is exactly 1 cycle from handshake to VRF write enable.
- Outputs are never held across cycles: each enable is asserted for one cycle per transfer.
- Zero mask with valid: accepted (ready=1); produces enables=0, no pend_o bit, and never conflicts.
- pend_o: OR of one-hot(v_wr_addr_o) when |v_wr_en_o and one-hot(el_wr_addr_o) when |el_wr_en_o. Purely combinational from the output registers.
- Same address on both ports with disjoint masks: both written in the same cycle. This is legal.
- Reset (any time, including mid-transfer): all enables 0, addresses and data 0, pend_o 0, readies 0 while rstn_i is low. An in-flight write is discarded.

Optional Feature:
- Macro CELLRV32_VRF_ARB_STATS_EN.
- When defined, add outputs conflict_cnt_o (32 bits) and starve_cnt_o (32 bits).
  - conflict_cnt_o counts conflict cycles.
  - starve_cnt_o counts forced priority switches.
  - Both saturate at all-ones and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package cellrv32_package gains:
  - typedef vrf_arb_state_t {PRIO_EX, PRIO_MEM}
  - localparam VRF_ARB_MAX_WAIT_DEF = 3
- One sub-module, vrf_wr_arb_fsm: holds the FSM and wait counter. Inputs are the conflict and grant signals; outputs are the winner select.
- Output registers and pend_o decoding stay in the top module.

Test Plan:
- EX addr 5 mask 0011, MEM addr 5 mask 1100, both valid -> both ready. Next cycle v_wr_en_o=0011, el_wr_en_o=1100, pend_o bit 5 only.
- Both valid, masks 0001/0001, state PRIO_EX, MEM held for 4 cycles -> EX wins 3 conflicts. MEM is forced to win the 4th, with the FSM in PRIO_MEM.
- Single EX request, addr 31, mask 1111, data 0xDEADBEEF per element -> v_wr_en_o=1111 exactly one cycle later, pend_o[31]=1 for one cycle only.
- EX valid with mask 0000, concurrent MEM mask 1111 -> no conflict, both ready; v_wr_en_o=0, el_wr_en_o=1111.
- Assert rstn_i low in the cycle after a handshake -> enables drop to 0 immediately. After reset the FSM is PRIO_EX and the counter is 0.
- With CELLRV32_VRF_ARB_STATS_EN defined, run the starvation scenario above -> conflict_cnt_o=4, starve_cnt_o=1.
